bfu_nopipe: RTL and testbench
=============================

// Module: bfu_nopipe
// PURPOSE
//   Single-stage (non-pipelined) modular butterfly unit for the NTT datapath.
//   Each enabled cycle it takes one operand pair (xin, yin) and a twiddle factor wr.
//   One clock later it returns the butterfly pair reduced modulo Q, with valid set.
//   Instantiated by the NTT/INTT controller; one butterfly per clock, no internal pipeline.
// PARAMETERS
//   Q   32'd4294967291 (2^32-5, prime)   modulus; requires 2 < Q < 2^(`Datawidth+1)
//   Data width comes from `Datawidth in define.v: W = `Datawidth+1 = 32 bits.
// PORTS
//   clk    in   1   single clock; all state updates on posedge
//   reset  in   1   asynchronous reset, active-low (0 = reset)
//   xin    in   W   butterfly upper operand, any W-bit value
//   yin    in   W   butterfly lower operand, any W-bit value
//   wr     in   W   twiddle factor, any W-bit value
//   en     in   1   operands valid this cycle; sampled on posedge
//   xout   out  W   upper result, registered, always in [0,Q-1]
//   yout   out  W   lower result, registered, always in [0,Q-1]
//   valid  out  1   xout/yout hold a fresh result this cycle
// BEHAVIOUR
//   - Reset (reset==0, async): xout=0, yout=0, valid=0, held until reset deasserts.
//   - Inputs first reduced: x'=xin mod Q, y'=yin mod Q, w'=wr mod Q.
//     W-bit inputs are < 2Q, so one conditional subtract suffices.
//   - Cooley-Tukey (default): t=(y'*w') mod Q over the full 2W-bit product;
//     xout=(x'+t) mod Q; yout=(x'-t) mod Q (add Q on borrow).
//   - Sums use a W+1-bit intermediate; no intermediate may wrap before reduction.
//   - Latency 1: en=1 at posedge N -> xout/yout/valid=1 updated at posedge N.
//     Visible throughout cycle N+1. Throughput 1 per clock.
//   - en=0 at a posedge: valid<=0; xout/yout hold their last value.
//   - Back-to-back en=1: each cycle's result replaces the previous one. No stall,
//     no backpressure.
//   - Reset asserted mid-stream: the in-flight result is discarded. After release,
//     the first result appears one posedge after the first sampled en=1.
//   - The reduced product may be computed combinationally (any exact reduction,
//     e.g. Barrett or %) provided it closes timing in one cycle.
//   - Boundaries:
//       xin/yin/wr = 2^W-1 reduce to 4 for the default Q.
//       Inputs equal to Q reduce to 0.
//       x'=t gives yout=0, never Q.
// CONFIGURATION
//   BFU_GS_MODE_EN defined: Gentleman-Sande butterfly for INTT:
//     xout=(x'+y') mod Q, yout=(((x'-y') mod Q)*w') mod Q.
//     Latency, valid and reset behaviour unchanged.
//   Not defined (default): Cooley-Tukey as above.
// TESTING (Q=4294967291, CT mode unless noted)
//   1 Hold reset=0, toggle en/inputs -> xout=0, yout=0, valid=0 throughout.
//   2 xin=5, yin=3, wr=1024, en=1 -> next cycle xout=3077, yout=4294964224, valid=1.
//   3 xin=32'hFFFFFFFF, yin=0, wr=1024 -> xout=4, yout=4.
//     Then en=0 -> valid=0, xout/yout hold 4.
//   4 xin=0, yin=Q-1, wr=Q-1 -> xout=1, yout=4294967290.
//     Also xin=7, yin=7, wr=1 -> yout=0.
//   5 en=1 for 8 cycles with random 32-bit inputs -> valid=1 every cycle.
//     Each result matches a reference model one cycle later.
//     Pull reset low mid-burst -> outputs clear immediately (async).
//   6 BFU_GS_MODE_EN: xin=10, yin=3, wr=2 -> xout=13, yout=14.
//     xin=3, yin=10, wr=1 -> yout=4294967284.

Source files
------------

// File: rtl/bfu_nopipe.sv
// Single-cycle modular butterfly (Cooley-Tukey by default, Gentleman-Sande
// when BFU_GS_MODE_EN is defined); width from `Datawidth (define.v).
`ifndef Datawidth
`define Datawidth 31
`endif

module bfu_nopipe #(
  parameter int W = `Datawidth + 1,
  parameter logic [W-1:0] Q = W'(32'd4294967291)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] xin,
  input  logic [W-1:0] yin,
  input  logic [W-1:0] wr,
  input  logic         en,
  output logic [W-1:0] xout,
  output logic [W-1:0] yout,
  output logic         valid
);

  // Any W-bit value is below 2Q, so one subtract reduces it.
  function automatic logic [W-1:0] red(input logic [W-1:0] a);
    return (a >= Q) ? a - Q : a;
  endfunction

  function automatic logic [W-1:0] addm(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return W'((s >= {1'b0, Q}) ? s - {1'b0, Q} : s);
  endfunction

  function automatic logic [W-1:0] subm(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, Q} - {1'b0, b};
    return (a >= b) ? a - b : W'(s);
  endfunction

  function automatic logic [W-1:0] mulm(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return W'(p % {{W{1'b0}}, Q});
  endfunction

  logic [W-1:0] xr, yr, wq;
  logic [W-1:0] xn, yn;

  assign xr = red(xin);
  assign yr = red(yin);
  assign wq = red(wr);

`ifdef BFU_GS_MODE_EN
  assign xn = addm(xr, yr);
  assign yn = mulm(subm(xr, yr), wq);
`else
  logic [W-1:0] t;
  assign t  = mulm(yr, wq);
  assign xn = addm(xr, t);
  assign yn = subm(xr, t);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xout  <= '0;
      yout  <= '0;
      valid <= 1'b0;
    end else if (en) begin
      xout  <= xn;
      yout  <= yn;
      valid <= 1'b1;
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bfu_nopipe.sv
// Self-checking bench for bfu_nopipe: directed table, random burst vs model,
// async reset mid-burst.
module tb_bfu_nopipe;

  localparam longint unsigned QM = 64'd4294967291;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] xin = '0, yin = '0, wr = '0;
  logic        en = 1'b0;
  logic [31:0] xout, yout;
  logic        valid;

  int pass_cnt = 0;
  int total_cnt = 0;

  longint unsigned mx = 0, my = 0;

  bfu_nopipe dut (
    .clk(clk), .reset(reset), .xin(xin), .yin(yin), .wr(wr),
    .en(en), .xout(xout), .yout(yout), .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x, y, w;
    logic        e;
    logic [31:0] ex, ey;
    logic        ev;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input longint unsigned act,
                       input longint unsigned exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic void model(
    input longint unsigned x, input longint unsigned y,
    input longint unsigned w,
    output longint unsigned ex, output longint unsigned ey
  );
    longint unsigned a, b, c, t;
    a = x % QM;
    b = y % QM;
    c = w % QM;
`ifdef BFU_GS_MODE_EN
    ex = (a + b) % QM;
    t  = (a + QM - b) % QM;
    ey = (t * c) % QM;
`else
    t  = (b * c) % QM;
    ex = (a + t) % QM;
    ey = (a + QM - t) % QM;
`endif
  endfunction

  task automatic step(input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] w, input logic e);
    @(negedge clk);
    xin = x; yin = y; wr = w; en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic step_model(input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] w, input logic e,
                            input string nm);
    longint unsigned ex, ey;
    step(x, y, w, e);
    if (e) begin
      model(x, y, w, ex, ey);
      mx = ex;
      my = ey;
    end
    check({nm, ".x"}, xout, mx);
    check({nm, ".y"}, yout, my);
    check({nm, ".v"}, valid, e);
  endtask

  initial begin
`ifdef BFU_GS_MODE_EN
    vecs[0] = '{32'd10, 32'd3, 32'd2, 1'b1, 32'd13, 32'd14, 1'b1};
    vecs[1] = '{32'd3, 32'd10, 32'd1, 1'b1, 32'd13, 32'd4294967284, 1'b1};
    vecs[2] = '{32'd0, 32'd0, 32'd0, 1'b0, 32'd13, 32'd4294967284, 1'b0};
    vecs[3] = '{32'hFFFFFFFF, 32'd0, 32'd1024, 1'b1, 32'd4, 32'd4096, 1'b1};
    vecs[4] = '{32'd4294967291, 32'd4294967291, 32'd4294967291, 1'b1,
                32'd0, 32'd0, 1'b1};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
                32'd8, 32'd0, 1'b1};
    vecs[6] = '{32'd7, 32'd7, 32'd1, 1'b1, 32'd14, 32'd0, 1'b1};
`else
    vecs[0] = '{32'd5, 32'd3, 32'd1024, 1'b1, 32'd3077, 32'd4294964224, 1'b1};
    vecs[1] = '{32'hFFFFFFFF, 32'd0, 32'd1024, 1'b1, 32'd4, 32'd4, 1'b1};
    vecs[2] = '{32'd0, 32'd0, 32'd0, 1'b0, 32'd4, 32'd4, 1'b0};
    vecs[3] = '{32'd0, 32'd4294967290, 32'd4294967290, 1'b1,
                32'd1, 32'd4294967290, 1'b1};
    vecs[4] = '{32'd7, 32'd7, 32'd1, 1'b1, 32'd14, 32'd0, 1'b1};
    vecs[5] = '{32'd4294967291, 32'd4294967291, 32'd4294967291, 1'b1,
                32'd0, 32'd0, 1'b1};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
                32'd20, 32'd4294967279, 1'b1};
`endif

    // Reset held: outputs stay cleared whatever en and inputs do.
    for (int i = 0; i < 4; i++) begin
      step($urandom, $urandom, $urandom, 1'(i % 2 == 0));
      check("rst_hold.x", xout, 0);
      check("rst_hold.y", yout, 0);
      check("rst_hold.v", valid, 0);
    end

    @(negedge clk);
    reset = 1'b1;
    en = 1'b0;

    for (int i = 0; i < 7; i++) begin
      step(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].e);
      check($sformatf("vec%0d.x", i), xout, vecs[i].ex);
      check($sformatf("vec%0d.y", i), yout, vecs[i].ey);
      check($sformatf("vec%0d.v", i), valid, vecs[i].ev);
    end
    mx = xout;
    my = yout;

    // Back-to-back random burst.
    for (int i = 0; i < 8; i++)
      step_model($urandom, $urandom, $urandom, 1'b1, "burst");

    // Async reset between edges clears outputs without a clock.
    #2;
    reset = 1'b0;
    #1;
    check("async_rst.x", xout, 0);
    check("async_rst.y", yout, 0);
    check("async_rst.v", valid, 0);
    mx = 0;
    my = 0;

    @(negedge clk);
    en = 1'b0;
    reset = 1'b1;
    step_model(32'd1, 32'd2, 32'd3, 1'b0, "post_rst_idle");
    step_model(32'd9, 32'd4, 32'd5, 1'b1, "post_rst_first");

    // Random traffic with gaps and values near Q.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] x, y, w;
      x = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - $urandom_range(0, 8)
                                      : $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'd4294967291 - $urandom_range(0, 2)
                                      : $urandom;
      w = ($urandom_range(0, 4) == 0) ? x : $urandom;
      step_model(x, y, w, 1'($urandom_range(0, 3) != 0), "rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
